mem_access_gen: RTL and testbench

Memory access generator for the PMBIST datapath, directly downstream of the cycle controller. Each clock it consumes the per-cycle operation and polarity selected by the control mux, plus the comparator's last-op strobe. From these it drives address, data and read/write strobes to the memory under test. It advances an up/down address counter across each march element and checks read data against the expected pattern, keeping a sticky fail flag and the first failing address.

---
 rtl/mem_access_gen.sv | 119 +++++++++++
 tb/tb_mem_access_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_gen.sv
// Memory access generator: issues march-element writes/reads, walks the address, compares read data.
// Latency: strobes/address/data registered 1 cycle after sampling; compare result 2 edges after read issue.
// Backpressure: none; the controller paces the element through en_in/cmp_in, reads pipeline with no stall.
module mem_access_gen #(
  parameter int aw = 8,
  parameter int dw = 8,
  parameter int ow = 4
) (
  input  logic          clk,
  input  logic          r_in,
  input  logic          start_in,
  input  logic          en_in,
  input  logic [ow-1:0] op_in,
  input  logic          pol_in,
  input  logic          cmp_in,
  input  logic          updwn_in,
  input  logic [dw-1:0] data_in,
  input  logic [dw-1:0] mem_q_in,
  output logic [aw-1:0] mem_addr_out,
  output logic [dw-1:0] mem_d_out,
  output logic          mem_we_out,
  output logic          mem_re_out,
  output logic          elem_done_out,
  output logic          fail_out,
  output logic [aw-1:0] fail_addr_out
);

  localparam logic [ow-1:0] OP_WR = ow'(1);
  localparam logic [ow-1:0] OP_RD = ow'(2);

  logic [aw-1:0] addr;
  logic [aw-1:0] start_addr;
  logic [aw-1:0] last_addr;
  logic [dw-1:0] pattern;

  // read pipeline: stage 1 covers the memory access cycle, stage 2 meets the returned data
  logic          s1_vld;
  logic [dw-1:0] s1_exp;
  logic [aw-1:0] s1_addr;
  logic          s2_vld;
  logic [dw-1:0] s2_exp;
  logic [aw-1:0] s2_addr;

  // direction decides both where an element starts and where it ends
  assign start_addr = updwn_in ? '0 : '1;
  assign last_addr  = updwn_in ? '1 : '0;
  assign pattern    = data_in ^ {dw{pol_in}};

  // access issue and address walk
  always_ff @(posedge clk) begin
    if (r_in) begin
      addr          <= '0;
      mem_addr_out  <= '0;
      mem_d_out     <= '0;
      mem_we_out    <= 1'b0;
      mem_re_out    <= 1'b0;
      elem_done_out <= 1'b0;
    end else begin
      mem_we_out    <= 1'b0;
      mem_re_out    <= 1'b0;
      elem_done_out <= 1'b0;
      if (en_in) begin
        mem_addr_out <= addr;
        if (op_in == OP_WR) begin
          mem_we_out <= 1'b1;
          mem_d_out  <= pattern;
        end else if (op_in == OP_RD) begin
          mem_re_out <= 1'b1;
        end
      end
      // the access above always uses the pre-update address; a start reload wins over advance
      if (start_in) begin
        addr <= start_addr;
      end else if (en_in && cmp_in) begin
        if (addr == last_addr) begin
          addr          <= start_addr;
          elem_done_out <= 1'b1;
        end else if (updwn_in) begin
          addr <= addr + aw'(1);
        end else begin
          addr <= addr - aw'(1);
        end
      end
    end
  end

  // expected-data pipeline tracking each read until its data returns
  always_ff @(posedge clk) begin
    if (r_in) begin
      s1_vld  <= 1'b0;
      s1_exp  <= '0;
      s1_addr <= '0;
      s2_vld  <= 1'b0;
      s2_exp  <= '0;
      s2_addr <= '0;
    end else begin
      s1_vld  <= en_in && (op_in == OP_RD);
      s1_exp  <= pattern;
      s1_addr <= addr;
      s2_vld  <= s1_vld;
      s2_exp  <= s1_exp;
      s2_addr <= s1_addr;
    end
  end

  // sticky fail flag; only the first failing address is kept
  always_ff @(posedge clk) begin
    if (r_in) begin
      fail_out      <= 1'b0;
      fail_addr_out <= '0;
    end else if (s2_vld && (mem_q_in != s2_exp)) begin
      fail_out <= 1'b1;
      if (!fail_out) begin
        fail_addr_out <= s2_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_gen.sv
module tb_mem_access_gen;

  logic       clk = 1'b0;
  logic       r_in, start_in, en_in, pol_in, cmp_in, updwn_in;
  logic [3:0] op_in;
  logic [7:0] data_in, mem_q_in;
  logic [2:0] mem_addr_out, fail_addr_out;
  logic [7:0] mem_d_out;
  logic       mem_we_out, mem_re_out, elem_done_out, fail_out;

  always #5 clk = ~clk;

  mem_access_gen #(.aw(3), .dw(8), .ow(4)) dut (
    .clk(clk), .r_in(r_in), .start_in(start_in), .en_in(en_in), .op_in(op_in),
    .pol_in(pol_in), .cmp_in(cmp_in), .updwn_in(updwn_in), .data_in(data_in),
    .mem_q_in(mem_q_in), .mem_addr_out(mem_addr_out), .mem_d_out(mem_d_out),
    .mem_we_out(mem_we_out), .mem_re_out(mem_re_out), .elem_done_out(elem_done_out),
    .fail_out(fail_out), .fail_addr_out(fail_addr_out)
  );

  // memory under test: 8 words, read data appears after the edge that samples the read
  logic [7:0] mem [8];
  logic [7:0] fault;
  always @(posedge clk) begin
    if (mem_we_out) mem[mem_addr_out] <= mem_d_out;
    if (mem_re_out) mem_q_in <= fault[mem_addr_out] ? 8'h00 : mem[mem_addr_out];
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: transaction-level view of the spec rules
  typedef struct { int due; logic [7:0] exp; int a; } rd_t;
  rd_t pend[$];
  int cyc = 0;
  int m_a = 0;
  logic       m_we = 0, m_re = 0, m_done = 0, m_fail = 0;
  logic [2:0] m_addr = 0, m_faddr = 0;
  logic [7:0] m_d = 0;

  task automatic model_step();
    rd_t t;
    logic [7:0] pat;
    int last, first;
    cyc++;
    if (r_in) begin
      m_we = 0; m_re = 0; m_done = 0; m_fail = 0;
      m_addr = 0; m_faddr = 0; m_d = 0; m_a = 0;
      pend.delete();
      return;
    end
    m_we = 0; m_re = 0; m_done = 0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      t = pend.pop_front();
      if (mem_q_in !== t.exp) begin
        if (!m_fail) m_faddr = 3'(t.a);
        m_fail = 1;
      end
    end
    pat = data_in ^ {8{pol_in}};
    first = updwn_in ? 0 : 7;
    last  = updwn_in ? 7 : 0;
    if (en_in) begin
      m_addr = 3'(m_a);
      if (op_in == 4'h1) begin
        m_we = 1; m_d = pat;
      end else if (op_in == 4'h2) begin
        m_re = 1;
        pend.push_back('{cyc + 2, pat, m_a});
      end
    end
    if (start_in) m_a = first;
    else if (en_in && cmp_in) begin
      if (m_a == last) begin m_done = 1; m_a = first; end
      else m_a = updwn_in ? m_a + 1 : m_a - 1;
    end
  endtask

  task automatic check_all();
    check("we",    32'(mem_we_out),    32'(m_we));
    check("re",    32'(mem_re_out),    32'(m_re));
    check("addr",  32'(mem_addr_out),  32'(m_addr));
    check("d",     32'(mem_d_out),     32'(m_d));
    check("done",  32'(elem_done_out), 32'(m_done));
    check("fail",  32'(fail_out),      32'(m_fail));
    check("faddr", 32'(fail_addr_out), 32'(m_faddr));
  endtask

  task automatic drive(input logic r, s, e, input logic [3:0] op,
                       input logic p, c, u, input logic [7:0] d);
    r_in = r; start_in = s; en_in = e; op_in = op;
    pol_in = p; cmp_in = c; updwn_in = u; data_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // one march element: start, then per address the ops a/b/c (per ops), cmp on the last
  task automatic element(input logic [3:0] op_a, op_b, op_c, input int per,
                         input logic u, p, input logic [7:0] d, output int dones);
    logic [3:0] op;
    dones = 0;
    drive(0, 1, 0, 4'h0, p, 0, u, d);
    tick();
    for (int a = 0; a < 8; a++) begin
      for (int k = 0; k < per; k++) begin
        op = (k == 0) ? op_a : (k == 1) ? op_b : op_c;
        drive(0, 0, 1, op, p, (k == per - 1), u, d);
        tick();
        if (elem_done_out) dones++;
      end
    end
    drive(0, 0, 0, 4'h0, p, 0, u, d);
    tick();
  endtask

  typedef struct {
    logic s, e, c, u, p;
    logic [3:0] op;
    logic [7:0] d;
    logic x_we, x_re, x_done;
    logic [2:0] x_addr;
    logic [7:0] x_d;
  } vec_t;

  vec_t vt[10];
  int dones;

  initial begin
    fault = 8'h00;
    drive(1, 0, 0, 4'h0, 0, 0, 1, 8'h00);

    // reset held with random inputs: everything must read zero
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 8'($urandom));
      tick();
      check("rst_we", 32'(mem_we_out), 0);
      check("rst_re", 32'(mem_re_out), 0);
      check("rst_addr", 32'(mem_addr_out), 0);
      check("rst_fail", 32'(fail_out), 0);
    end
    drive(0, 0, 0, 4'h1, 0, 1, 1, 8'h55);
    tick();
    check("idle_we", 32'(mem_we_out), 0);

    // up write element of 0x55, table-driven
    vt[0] = '{s:1, e:0, c:0, u:1, p:0, op:4'h1, d:8'h55, x_we:0, x_re:0, x_done:0, x_addr:0, x_d:8'h00};
    for (int i = 1; i <= 8; i++)
      vt[i] = '{s:0, e:1, c:1, u:1, p:0, op:4'h1, d:8'h55, x_we:1, x_re:0,
                x_done:(i == 8), x_addr:3'(i - 1), x_d:8'h55};
    vt[9] = '{s:0, e:0, c:1, u:1, p:0, op:4'h1, d:8'h55, x_we:0, x_re:0, x_done:0, x_addr:3'd7, x_d:8'h55};
    for (int i = 0; i < 10; i++) begin
      drive(0, vt[i].s, vt[i].e, vt[i].op, vt[i].p, vt[i].c, vt[i].u, vt[i].d);
      tick();
      check("tbl_we",   32'(mem_we_out),    32'(vt[i].x_we));
      check("tbl_re",   32'(mem_re_out),    32'(vt[i].x_re));
      check("tbl_addr", 32'(mem_addr_out),  32'(vt[i].x_addr));
      check("tbl_d",    32'(mem_d_out),     32'(vt[i].x_d));
      check("tbl_done", 32'(elem_done_out), 32'(vt[i].x_done));
    end

    // fill 0xAA, then read it back downward with inverted polarity
    element(4'h1, 4'h0, 4'h0, 1, 1, 1, 8'h55, dones);
    check("wr_dones", 32'(dones), 1);
    element(4'h2, 4'h0, 4'h0, 1, 0, 1, 8'h55, dones);
    drive(0, 0, 0, 4'h0, 1, 0, 0, 8'h55);
    tick(); tick();
    check("clean_fail", 32'(fail_out), 0);
    check("rd_dones", 32'(dones), 1);

    // faults at 5 then 2: first one is latched
    fault[5] = 1'b1; fault[2] = 1'b1;
    element(4'h2, 4'h0, 4'h0, 1, 0, 1, 8'h55, dones);
    tick(); tick();
    check("flt_fail", 32'(fail_out), 1);
    check("flt_addr", 32'(fail_addr_out), 5);

    // read/write/read per address, advance every third cycle
    element(4'h2, 4'h1, 4'h2, 3, 1, 1, 8'h55, dones);
    tick(); tick();
    check("multi_dones", 32'(dones), 1);
    check("multi_faddr", 32'(fail_addr_out), 5);

    // reset one cycle after a read that would mismatch
    drive(1, 0, 0, 4'h0, 1, 0, 1, 8'h55); tick();
    fault[0] = 1'b1;
    drive(0, 1, 0, 4'h0, 1, 0, 1, 8'h55); tick();
    drive(0, 0, 1, 4'h2, 1, 0, 1, 8'h55); tick();
    check("pre_rst_re", 32'(mem_re_out), 1);
    drive(1, 0, 0, 4'h0, 1, 0, 1, 8'h55); tick();
    check("mid_rst_re", 32'(mem_re_out), 0);
    check("mid_rst_addr", 32'(mem_addr_out), 0);
    check("mid_rst_fail", 32'(fail_out), 0);
    drive(0, 0, 0, 4'h0, 1, 0, 1, 8'h55);
    tick(); tick();
    check("post_rst_fail", 32'(fail_out), 0);

    // randomized traffic against the model
    for (int i = 0; i < 8; i++) fault[i] = ($urandom_range(0, 4) == 0);
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [3:0] op;
      k = $urandom_range(0, 5);
      op = (k < 2) ? 4'h1 : (k < 4) ? 4'h2 : 4'($urandom);
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, op, 1'($urandom), 1'($urandom),
            1'($urandom), 8'($urandom));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
